// File: rtl/psum_wb_ctrl_pkg.sv
// Shared definitions for the partial-sum writeback controller:
// FSM state encoding and signed saturation limits.
package psum_wb_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_ACC_RD = 3'd2,
      ST_ACC_WR = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Limits are returned 64 bits wide; callers keep the low bw bits.
   function automatic logic [63:0] sat_max(input int unsigned bw);
      return (64'd1 << (bw - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int unsigned bw);
      return ~sat_max(bw);
   endfunction

endpackage

// File: rtl/psum_wb_ctrl_if.sv
// OFIFO read port plus psum SRAM port, as seen by the writeback controller.
interface psum_wb_ctrl_if #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_w  = 11
);
   logic                     ofifo_valid;
   logic [psum_bw*col-1:0]   ofifo_rdata;
   logic                     ofifo_rd;
   logic                     sram_cen;
   logic                     sram_wen;
   logic [addr_w-1:0]        sram_addr;
   logic [psum_bw*col-1:0]   sram_wdata;
   logic [psum_bw*col-1:0]   sram_rdata;

   modport master (
      input  ofifo_valid, ofifo_rdata, sram_rdata,
      output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
   );

   modport slave (
      output ofifo_valid, ofifo_rdata, sram_rdata,
      input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
   );
endinterface

// File: rtl/psum_sat_add.sv
// One lane of the accumulate path: signed add clamped to the lane range.
module psum_sat_add
   import psum_wb_ctrl_pkg::*;
#(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] a_i,
   input  logic [psum_bw-1:0] b_i,
   output logic [psum_bw-1:0] sum_o
);
   localparam logic [63:0]        MAX64 = sat_max(psum_bw);
   localparam logic [63:0]        MIN64 = sat_min(psum_bw);
   localparam logic [psum_bw-1:0] MAX_V = MAX64[psum_bw-1:0];
   localparam logic [psum_bw-1:0] MIN_V = MIN64[psum_bw-1:0];

   logic [psum_bw:0] wide;

   assign wide = {a_i[psum_bw-1], a_i} + {b_i[psum_bw-1], b_i};

   // Overflow shows up as the extra sign bit disagreeing with the lane MSB.
   always_comb begin
      sum_o = wide[psum_bw-1:0];
      if (wide[psum_bw] != wide[psum_bw-1]) begin
         sum_o = wide[psum_bw] ? MIN_V : MAX_V;
      end
   end
endmodule

// File: rtl/psum_wb_ctrl.sv
// Drains OFIFO entries into psum SRAM, either overwriting rows or
// read-modify-writing them with a per-lane saturating add.
module psum_wb_ctrl
   import psum_wb_ctrl_pkg::*;
#(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_w  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              acc_en,
   input  logic [addr_w-1:0] base_addr,
   input  logic [addr_w:0]   num_rows,
   output logic              busy,
   output logic              done,
   psum_wb_ctrl_if.master    bus
);
   localparam int              DW      = psum_bw * col;
   localparam logic [addr_w:0] REM_ONE = 1;

   state_e            state_q, state_d;
   logic [addr_w-1:0] ptr_q, ptr_d;
   logic [addr_w:0]   rem_q, rem_d;
   logic              mode_q, mode_d;
   logic [DW-1:0]     hold_q, hold_d;
   logic [DW-1:0]     sat_sum;

   for (genvar gi = 0; gi < col; gi++) begin : g_lane
      psum_sat_add #(.psum_bw(psum_bw)) u_sat_add (
         .a_i   (hold_q[gi*psum_bw +: psum_bw]),
         .b_i   (bus.sram_rdata[gi*psum_bw +: psum_bw]),
         .sum_o (sat_sum[gi*psum_bw +: psum_bw])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         mode_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      rem_d          = rem_q;
      mode_d         = mode_q;
      hold_d         = hold_q;
      busy           = 1'b1;
      done           = 1'b0;
      bus.ofifo_rd   = 1'b0;
      bus.sram_cen   = 1'b1;
      bus.sram_wen   = 1'b1;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               ptr_d  = base_addr;
               rem_d  = num_rows;
               mode_d = acc_en;
               if (num_rows == '0) begin
                  state_d = ST_DONE;
               end else if (acc_en) begin
                  state_d = ST_ACC_RD;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end

         // Write straight through from the FIFO head; a stall leaves the SRAM deselected.
         ST_DRAIN: begin
            bus.ofifo_rd   = bus.ofifo_valid;
            bus.sram_cen   = ~bus.ofifo_valid;
            bus.sram_wen   = 1'b0;
            bus.sram_addr  = ptr_q;
            bus.sram_wdata = bus.ofifo_rdata;
            if (bus.ofifo_valid) begin
               ptr_d = ptr_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_ONE) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACC_RD: begin
            if (bus.ofifo_valid) begin
               bus.ofifo_rd  = 1'b1;
               bus.sram_cen  = 1'b0;
               bus.sram_wen  = 1'b1;
               bus.sram_addr = ptr_q;
               hold_d        = bus.ofifo_rdata;
               state_d       = ST_ACC_WR;
            end
         end

         // SRAM read data for ptr arrives this cycle, one cycle after the read.
         ST_ACC_WR: begin
            bus.sram_cen   = 1'b0;
            bus.sram_wen   = 1'b0;
            bus.sram_addr  = ptr_q;
            bus.sram_wdata = sat_sum;
            ptr_d          = ptr_q + 1'b1;
            rem_d          = rem_q - 1'b1;
            if (rem_q == REM_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = mode_q ? ST_ACC_RD : ST_DRAIN;
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_psum_wb_ctrl.sv
// Directed bench for psum_wb_ctrl with a behavioural SRAM and hand-computed results.
module tb_psum_wb_ctrl;
   localparam int PBW = 16;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam int DW  = PBW * COL;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          acc_en = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_rows = '0;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   psum_wb_ctrl_if #(.psum_bw(PBW), .col(COL), .addr_w(AW)) bus_if ();

   psum_wb_ctrl #(.psum_bw(PBW), .col(COL), .addr_w(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .acc_en    (acc_en),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .busy      (busy),
      .done      (done),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: one-cycle read latency, with a preload port for setup.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   int            wr_cnt = 0;
   int            rd_cnt = 0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (!bus_if.sram_cen) begin
         if (!bus_if.sram_wen) begin
            mem[bus_if.sram_addr] <= bus_if.sram_wdata;
            wr_cnt <= wr_cnt + 1;
         end else begin
            bus_if.sram_rdata <= mem[bus_if.sram_addr];
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0;
      bus_if.ofifo_valid = 1'b0; bus_if.ofifo_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      total++; if ({busy, done, bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen} !== 5'b00011) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=00011", {busy, done, bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen}); end
      total++; if (bus_if.sram_addr !== 11'h000) begin
         bad++; $display("FAIL reset_addr got=%h exp=000", bus_if.sram_addr); end
      total++; if (bus_if.sram_wdata !== {DW{1'b0}}) begin
         bad++; $display("FAIL reset_wdata got=%h exp=0", bus_if.sram_wdata); end
      reset = 1'b1;
      $display("[tb] reset: outputs checked");
   endtask

   task automatic test_drain();
      int w0;
      logic [DW-1:0] exp_d;
      @(negedge clk);
      w0 = wr_cnt;
      start = 1'b1; acc_en = 1'b0; base_addr = 11'h010; num_rows = 12'd4;
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'h1100}};
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle_busy got=%b exp=0", busy); end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_d = {8{16'h1100 + 16'(i)}};
         bus_if.ofifo_rdata = exp_d;
         #1;
         total++; if ({bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen, busy} !== 4'b1001) begin
            bad++; $display("FAIL drain_ctrl%0d got=%b exp=1001", i, {bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen, busy}); end
         total++; if (bus_if.sram_addr !== 11'h010 + 11'(i)) begin
            bad++; $display("FAIL drain_addr%0d got=%h exp=%h", i, bus_if.sram_addr, 11'h010 + 11'(i)); end
         total++; if (bus_if.sram_wdata !== exp_d) begin
            bad++; $display("FAIL drain_wdata%0d got=%h exp=%h", i, bus_if.sram_wdata, exp_d); end
         @(negedge clk);
      end
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if ({done, busy, bus_if.sram_cen, bus_if.ofifo_rd} !== 4'b1110) begin
         bad++; $display("FAIL drain_done got=%b exp=1110", {done, busy, bus_if.sram_cen, bus_if.ofifo_rd}); end
      @(negedge clk);
      #1;
      total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL drain_after got=%b exp=00", {done, busy}); end
      total++; if (wr_cnt - w0 != 4) begin bad++; $display("FAIL drain_wrcnt got=%0d exp=4", wr_cnt - w0); end
      total++; if (mem[11'h013] !== {8{16'h1103}}) begin bad++; $display("FAIL drain_mem got=%h exp=%h", mem[11'h013], {8{16'h1103}}); end
      $display("[tb] drain: base=010 rows=4");
   endtask

   task automatic test_accumulate();
      logic [DW-1:0] exp_w;
      exp_w = {96'h0, 16'h000C, 16'h0046};
      preload(11'h020, {96'h0, 16'h0005, 16'h0064});
      @(negedge clk);
      start = 1'b1; acc_en = 1'b1; base_addr = 11'h020; num_rows = 12'd1;
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {96'h0, 16'h0007, 16'hFFE2};
      @(negedge clk);
      start = 1'b0;
      #1;
      total++; if ({bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen} !== 3'b101 || bus_if.sram_addr !== 11'h020) begin
         bad++; $display("FAIL acc_rd got=%b/%h exp=101/020", {bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen}, bus_if.sram_addr); end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if ({bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen} !== 3'b000 || bus_if.sram_addr !== 11'h020) begin
         bad++; $display("FAIL acc_wr got=%b/%h exp=000/020", {bus_if.ofifo_rd, bus_if.sram_cen, bus_if.sram_wen}, bus_if.sram_addr); end
      total++; if (bus_if.sram_wdata !== exp_w) begin
         bad++; $display("FAIL acc_wdata got=%h exp=%h", bus_if.sram_wdata, exp_w); end
      @(negedge clk);
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL acc_done got=%b exp=1", done); end
      @(negedge clk);
      #1;
      total++; if (mem[11'h020] !== exp_w) begin bad++; $display("FAIL acc_mem got=%h exp=%h", mem[11'h020], exp_w); end
      $display("[tb] accumulate: 100 + -30 at 020");
   endtask

   task automatic test_saturation();
      logic [DW-1:0] exp0, exp1;
      exp0 = {112'h0, 16'h7FFF};
      exp1 = {80'h0, 16'h7FFF, 16'h8000, 16'h8000};
      preload(11'h030, {112'h0, 16'h2000});
      preload(11'h031, {80'h0, 16'h3FFF, 16'h8000, 16'hFFFF});
      @(negedge clk);
      start = 1'b1; acc_en = 1'b1; base_addr = 11'h030; num_rows = 12'd2;
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {112'h0, 16'h7000};
      @(negedge clk);
      start = 1'b0;
      #1;
      total++; if (bus_if.ofifo_rd !== 1'b1 || bus_if.sram_addr !== 11'h030) begin
         bad++; $display("FAIL sat_rd0 got=%b/%h exp=1/030", bus_if.ofifo_rd, bus_if.sram_addr); end
      @(negedge clk);
      bus_if.ofifo_rdata = {80'h0, 16'h4000, 16'h8001, 16'h8000};
      #1;
      total++; if (bus_if.ofifo_rd !== 1'b0 || bus_if.sram_wdata !== exp0) begin
         bad++; $display("FAIL sat_pos got=%b/%h exp=0/%h", bus_if.ofifo_rd, bus_if.sram_wdata, exp0); end
      @(negedge clk);
      #1;
      total++; if (bus_if.ofifo_rd !== 1'b1 || bus_if.sram_addr !== 11'h031) begin
         bad++; $display("FAIL sat_rd1 got=%b/%h exp=1/031", bus_if.ofifo_rd, bus_if.sram_addr); end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if (bus_if.sram_wdata !== exp1 || bus_if.sram_addr !== 11'h031) begin
         bad++; $display("FAIL sat_neg got=%h/%h exp=%h/031", bus_if.sram_wdata, bus_if.sram_addr, exp1); end
      @(negedge clk);
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done got=%b exp=1", done); end
      $display("[tb] saturation: two rows at 030");
   endtask

   task automatic test_stall();
      int w0, r0;
      @(negedge clk);
      w0 = wr_cnt; r0 = rd_cnt;
      start = 1'b1; acc_en = 1'b0; base_addr = 11'h040; num_rows = 12'd2;
      bus_if.ofifo_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'hA5A5}};
      #1;
      total++; if ({bus_if.ofifo_rd, bus_if.sram_cen} !== 2'b10 || bus_if.sram_addr !== 11'h040) begin
         bad++; $display("FAIL stall_w0 got=%b/%h exp=10/040", {bus_if.ofifo_rd, bus_if.sram_cen}, bus_if.sram_addr); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus_if.ofifo_valid = 1'b0;
         #1;
         total++; if ({bus_if.ofifo_rd, bus_if.sram_cen, busy, done} !== 4'b0110) begin
            bad++; $display("FAIL stall_idle%0d got=%b exp=0110", i, {bus_if.ofifo_rd, bus_if.sram_cen, busy, done}); end
      end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'h5A5A}};
      #1;
      total++; if ({bus_if.ofifo_rd, bus_if.sram_cen} !== 2'b10 || bus_if.sram_addr !== 11'h041) begin
         bad++; $display("FAIL stall_w1 got=%b/%h exp=10/041", {bus_if.ofifo_rd, bus_if.sram_cen}, bus_if.sram_addr); end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
      total++; if (wr_cnt - w0 != 2 || rd_cnt != r0) begin
         bad++; $display("FAIL stall_count got=%0d/%0d exp=2/0", wr_cnt - w0, rd_cnt - r0); end
      total++; if (mem[11'h041] !== {8{16'h5A5A}}) begin bad++; $display("FAIL stall_mem got=%h exp=%h", mem[11'h041], {8{16'h5A5A}}); end
      $display("[tb] stall: valid 1,0,0,1");
   endtask

   task automatic test_zero();
      @(negedge clk);
      start = 1'b1; acc_en = 1'b1; base_addr = 11'h070; num_rows = 12'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      total++; if ({done, busy, bus_if.sram_cen, bus_if.ofifo_rd} !== 4'b1110) begin
         bad++; $display("FAIL zero_done got=%b exp=1110", {done, busy, bus_if.sram_cen, bus_if.ofifo_rd}); end
      @(negedge clk);
      #1;
      total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_after got=%b exp=00", {done, busy}); end
      $display("[tb] zero rows: immediate done");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      start = 1'b1; acc_en = 1'b0; base_addr = 11'h7FF; num_rows = 12'd2;
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'h0C0C}};
      @(negedge clk);
      start = 1'b0;
      #1;
      total++; if (bus_if.sram_addr !== 11'h7FF) begin bad++; $display("FAIL wrap_a0 got=%h exp=7ff", bus_if.sram_addr); end
      @(negedge clk);
      bus_if.ofifo_rdata = {8{16'h0D0D}};
      #1;
      total++; if (bus_if.sram_addr !== 11'h000 || bus_if.sram_cen !== 1'b0) begin
         bad++; $display("FAIL wrap_a1 got=%h/%b exp=000/0", bus_if.sram_addr, bus_if.sram_cen); end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if (done !== 1'b1 || mem[11'h000] !== {8{16'h0D0D}}) begin
         bad++; $display("FAIL wrap_end got=%b/%h exp=1/%h", done, mem[11'h000], {8{16'h0D0D}}); end
      $display("[tb] wrap: 7ff then 000");
   endtask

   task automatic test_reset_mid();
      preload(11'h050, {8{16'h0001}});
      @(negedge clk);
      start = 1'b1; acc_en = 1'b1; base_addr = 11'h050; num_rows = 12'd2;
      bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'h0002}};
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0; bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if ({bus_if.sram_cen, bus_if.sram_wen, busy} !== 3'b001) begin
         bad++; $display("FAIL rstmid_wr got=%b exp=001", {bus_if.sram_cen, bus_if.sram_wen, busy}); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if ({busy, done, bus_if.sram_cen, bus_if.ofifo_rd} !== 4'b0010) begin
         bad++; $display("FAIL rstmid_idle got=%b exp=0010", {busy, done, bus_if.sram_cen, bus_if.ofifo_rd}); end
      @(negedge clk);
      #1;
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_nodone got=%b exp=00", {busy, done}); end
      $display("[tb] reset mid-pass: back to idle");
   endtask

   task automatic test_start_ignored();
      @(negedge clk);
      start = 1'b1; acc_en = 1'b0; base_addr = 11'h060; num_rows = 12'd2;
      bus_if.ofifo_valid = 1'b0;
      @(negedge clk);
      start = 1'b1; acc_en = 1'b1; base_addr = 11'h100; num_rows = 12'd0;
      #1;
      total++; if ({busy, bus_if.sram_cen} !== 2'b11) begin bad++; $display("FAIL ign_busy got=%b exp=11", {busy, bus_if.sram_cen}); end
      @(negedge clk);
      start = 1'b0; bus_if.ofifo_valid = 1'b1; bus_if.ofifo_rdata = {8{16'h0E0E}};
      #1;
      total++; if (done !== 1'b0 || bus_if.ofifo_rd !== 1'b1 || bus_if.sram_addr !== 11'h060) begin
         bad++; $display("FAIL ign_w0 got=%b/%b/%h exp=0/1/060", done, bus_if.ofifo_rd, bus_if.sram_addr); end
      @(negedge clk);
      #1;
      total++; if (bus_if.sram_addr !== 11'h061 || bus_if.sram_wen !== 1'b0) begin
         bad++; $display("FAIL ign_w1 got=%h/%b exp=061/0", bus_if.sram_addr, bus_if.sram_wen); end
      @(negedge clk);
      bus_if.ofifo_valid = 1'b0;
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b exp=1", done); end
      @(negedge clk);
      $display("[tb] start while busy: ignored");
   endtask

   initial begin
      test_reset();
      test_drain();
      test_accumulate();
      test_saturation();
      test_stall();
      test_zero();
      test_wrap();
      test_reset_mid();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
